// File: rtl/pipe_hold_ctrl.sv
// Pipeline hazard/redirect controller: arbitrates jumps, interrupt entry, multi-cycle EX,
// load-use and fetch waits, and drives hold (load NOP) / stall (keep) for PC, IF/ID and ID/EX.
module pipe_hold_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int FLUSH_CYC     = 2,
    parameter int INT_DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_req_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              ex_busy_i,
    input  logic              load_use_i,
    input  logic              bus_wait_i,
    input  logic              int_req_i,
    input  logic [ADDR_W-1:0] int_addr_i,
    output logic              pc_hold_o,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              if_id_hold_o,
    output logic              if_id_stall_o,
    output logic              id_ex_hold_o,
    output logic              id_ex_stall_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        INT_WAIT,
        INT_DRAIN
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(INT_DRAIN_CYC - 1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              int_pend_q, int_pend_d;
    logic [ADDR_W-1:0] int_addr_q, int_addr_d;

    logic              pc_hold_c, pc_load_c;
    logic              if_id_hold_c, if_id_stall_c;
    logic              id_ex_hold_c, id_ex_stall_c;
    logic [ADDR_W-1:0] redirect_c;

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            int_pend_q <= 1'b0;
            int_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            int_pend_q <= int_pend_d;
            int_addr_q <= int_addr_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        cnt_d         = cnt_q;
        int_pend_d    = int_pend_q;
        int_addr_d    = int_addr_q;
        pc_hold_c     = 1'b0;
        pc_load_c     = 1'b0;
        redirect_c    = '0;
        if_id_hold_c  = 1'b0;
        if_id_stall_c = 1'b0;
        id_ex_hold_c  = 1'b0;
        id_ex_stall_c = 1'b0;

        // First request wins; later pulses are dropped until the handler redirect is issued.
        if (int_req_i && !int_pend_q) begin
            int_pend_d = 1'b1;
            int_addr_d = int_addr_i;
        end

        unique case (state_q)
            RUN: begin
                if (int_pend_q || int_req_i) begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                    state_d      = INT_WAIT;
                end else if (jump_req_i) begin
                    pc_load_c    = 1'b1;
                    redirect_c   = jump_addr_i;
                    if_id_hold_c = 1'b1;
                    id_ex_hold_c = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (ex_busy_i) begin
                    pc_hold_c     = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_stall_c = 1'b1;
                end else if (load_use_i) begin
                    pc_hold_c     = 1'b1;
                    if_id_stall_c = 1'b1;
                    id_ex_hold_c  = 1'b1;
                end else if (bus_wait_i) begin
                    pc_hold_c    = 1'b1;
                    if_id_hold_c = 1'b1;
                end
            end

            FLUSH: begin
                // Wrong-path instructions: any jump request here is ignored.
                if_id_hold_c = 1'b1;
                id_ex_hold_c = 1'b1;
                cnt_d        = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = RUN;
                end
            end

            INT_WAIT: begin
                pc_hold_c     = 1'b1;
                if_id_hold_c  = 1'b1;
                id_ex_stall_c = ex_busy_i;
                id_ex_hold_c  = ~ex_busy_i;
                if (!ex_busy_i) begin
                    state_d = INT_DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end

            INT_DRAIN: begin
                pc_hold_c    = 1'b1;
                if_id_hold_c = 1'b1;
                id_ex_hold_c = 1'b1;
                if (cnt_q == 3'd0) begin
                    pc_load_c  = 1'b1;
                    redirect_c = int_addr_q;
                    int_pend_d = 1'b0;
                    state_d    = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: state_d = RUN;
        endcase
    end

    // Outputs are forced low for the whole reset assertion, regardless of inputs.
    assign pc_hold_o       = rst & pc_hold_c;
    assign pc_load_o       = rst & pc_load_c;
    assign redirect_addr_o = rst ? redirect_c : '0;
    assign if_id_hold_o    = rst & if_id_hold_c;
    assign if_id_stall_o   = rst & if_id_stall_c;
    assign id_ex_hold_o    = rst & id_ex_hold_c;
    assign id_ex_stall_o   = rst & id_ex_stall_c;
    assign busy_o          = rst & (state_q != RUN);

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Bench for pipe_hold_ctrl: a bubble-count/queue model checked every cycle,
// plus hand-computed literal expectations for the directed scenarios.
module tb_pipe_hold_ctrl;

    localparam int ADDR_W        = 32;
    localparam int FLUSH_CYC     = 2;
    localparam int INT_DRAIN_CYC = 3;
    localparam int VW            = ADDR_W + 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              jump_req_i, ex_busy_i, load_use_i, bus_wait_i, int_req_i;
    logic [ADDR_W-1:0] jump_addr_i, int_addr_i;
    logic              pc_hold_o, pc_load_o, if_id_hold_o, if_id_stall_o;
    logic              id_ex_hold_o, id_ex_stall_o, busy_o;
    logic [ADDR_W-1:0] redirect_addr_o;

    int errors = 0;
    int checks = 0;

    pipe_hold_ctrl #(
        .ADDR_W(ADDR_W), .FLUSH_CYC(FLUSH_CYC), .INT_DRAIN_CYC(INT_DRAIN_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .jump_req_i(jump_req_i), .jump_addr_i(jump_addr_i),
        .ex_busy_i(ex_busy_i), .load_use_i(load_use_i), .bus_wait_i(bus_wait_i),
        .int_req_i(int_req_i), .int_addr_i(int_addr_i),
        .pc_hold_o(pc_hold_o), .pc_load_o(pc_load_o), .redirect_addr_o(redirect_addr_o),
        .if_id_hold_o(if_id_hold_o), .if_id_stall_o(if_id_stall_o),
        .id_ex_hold_o(id_ex_hold_o), .id_ex_stall_o(id_ex_stall_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // {redirect, pc_hold, pc_load, if_id_hold, if_id_stall, id_ex_hold, id_ex_stall, busy}
    logic [VW-1:0] dut_vec;
    assign dut_vec = {redirect_addr_o, pc_hold_o, pc_load_o, if_id_hold_o, if_id_stall_o,
                      id_ex_hold_o, id_ex_stall_o, busy_o};

    function automatic logic [VW-1:0] v(input logic [ADDR_W-1:0] redir,
                                        input logic ph, pl, ih, is, eh, es, b);
        return {redir, ph, pl, ih, is, eh, es, b};
    endfunction

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got redir=%h flags=%b, expected redir=%h flags=%b",
                     name, $time, got[VW-1:7], got[6:0], exp[VW-1:7], exp[6:0]);
        end
    endtask

    // Model: bubbles left in a jump flush, interrupt wait flag, drain cycles left,
    // and a queue holding the accepted handler address.
    int                flush_left = 0;
    bit                waiting    = 0;
    int                drain_left = 0;
    logic [ADDR_W-1:0] pend[$];

    function automatic logic [VW-1:0] model_out();
        logic [VW-1:0] e;
        e = '0;
        if (!rst) return e;
        if (drain_left > 0) begin
            e = v('0, 1, 0, 1, 0, 1, 0, 1);
            if (drain_left == 1) e = v(pend[0], 1, 1, 1, 0, 1, 0, 1);
        end else if (waiting) begin
            e = v('0, 1, 0, 1, 0, !ex_busy_i, ex_busy_i, 1);
        end else if (flush_left > 0) begin
            e = v('0, 0, 0, 1, 0, 1, 0, 1);
        end else if (pend.size() != 0 || int_req_i) begin
            e = v('0, 1, 0, 1, 0, 0, 0, 0);
        end else if (jump_req_i) begin
            e = v(jump_addr_i, 0, 1, 1, 0, 1, 0, 0);
        end else if (ex_busy_i) begin
            e = v('0, 1, 0, 0, 1, 0, 1, 0);
        end else if (load_use_i) begin
            e = v('0, 1, 0, 0, 1, 1, 0, 0);
        end else if (bus_wait_i) begin
            e = v('0, 1, 0, 1, 0, 0, 0, 0);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_left = 0;
            waiting    = 0;
            drain_left = 0;
            pend.delete();
        end else begin
            bit was_empty;
            was_empty = (pend.size() == 0);
            if (drain_left > 0) begin
                if (drain_left == 1) void'(pend.pop_front());
                drain_left--;
            end else if (waiting) begin
                if (!ex_busy_i) begin
                    waiting    = 0;
                    drain_left = INT_DRAIN_CYC;
                end
            end else if (flush_left > 0) begin
                flush_left--;
            end else if (!was_empty || int_req_i) begin
                waiting = 1;
            end else if (jump_req_i) begin
                flush_left = FLUSH_CYC - 1;
            end
            if (int_req_i && was_empty) pend.push_back(int_addr_i);
        end
    end

    always @(negedge clk) check("model", dut_vec, model_out());

    task automatic step(input logic jr, input logic [ADDR_W-1:0] ja, input logic eb,
                        input logic lu, input logic bw, input logic ir,
                        input logic [ADDR_W-1:0] ia);
        @(posedge clk);
        #1;
        jump_req_i  = jr;
        jump_addr_i = ja;
        ex_busy_i   = eb;
        load_use_i  = lu;
        bus_wait_i  = bw;
        int_req_i   = ir;
        int_addr_i  = ia;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, 0, 0, '0);
    endtask

    task automatic hand(input string name, input logic [VW-1:0] exp);
        @(negedge clk);
        #1;
        check(name, dut_vec, exp);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        jump_req_i  = 1'b1;
        jump_addr_i = '1;
        ex_busy_i   = 1'b1;
        load_use_i  = 1'b1;
        bus_wait_i  = 1'b1;
        int_req_i   = 1'b1;
        int_addr_i  = '1;

        #2 check("reset_all_ones", dut_vec, '0);
        repeat (2) @(posedge clk);
        hand("reset_held", '0);

        @(posedge clk);
        #1;
        {jump_req_i, ex_busy_i, load_use_i, bus_wait_i, int_req_i} = '0;
        jump_addr_i = '0;
        int_addr_i  = '0;
        rst         = 1'b1;
        hand("reset_release", '0);

        // Jump with a 2-cycle flush; a second jump during the flush is ignored.
        step(1, 32'h100, 0, 0, 0, 0, '0);
        hand("jump_c0", v(32'h100, 0, 1, 1, 0, 1, 0, 0));
        idle();
        hand("jump_c1", v('0, 0, 0, 1, 0, 1, 0, 1));
        idle();
        hand("jump_c2", '0);
        step(1, 32'h40, 0, 0, 0, 0, '0);
        step(1, 32'h200, 0, 0, 0, 0, '0);
        hand("jump_in_flush", v('0, 0, 0, 1, 0, 1, 0, 1));

        // Multi-cycle EX over a load-use hazard, then the lone load-use bubble.
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1, 1, 0, 0, '0);
            hand("ex_busy", v('0, 1, 0, 0, 1, 0, 1, 0));
        end
        step(0, '0, 0, 1, 0, 0, '0);
        hand("load_use", v('0, 1, 0, 0, 1, 1, 0, 0));
        step(0, '0, 0, 0, 1, 0, '0);
        hand("bus_wait", v('0, 1, 0, 1, 0, 0, 0, 0));
        idle();

        // Interrupt during a multi-cycle op; later int pulse and a jump are ignored.
        step(0, '0, 1, 0, 0, 1, 32'h80);
        hand("int_c0", v('0, 1, 0, 1, 0, 0, 0, 0));
        step(0, '0, 1, 0, 0, 0, '0);
        hand("int_wait_busy", v('0, 1, 0, 1, 0, 0, 1, 1));
        step(0, '0, 0, 0, 0, 1, 32'h44);
        hand("int_wait_free", v('0, 1, 0, 1, 0, 1, 0, 1));
        idle();
        hand("int_drain0", v('0, 1, 0, 1, 0, 1, 0, 1));
        step(1, 32'h300, 0, 0, 0, 0, '0);
        hand("int_drain1_jump", v('0, 1, 0, 1, 0, 1, 0, 1));
        idle();
        hand("int_redirect", v(32'h80, 1, 1, 1, 0, 1, 0, 1));
        idle();
        hand("int_done", '0);

        // Interrupt and jump together: interrupt path, no load to the jump target.
        step(1, 32'h100, 0, 0, 0, 1, 32'h90);
        hand("int_vs_jump", v('0, 1, 0, 1, 0, 0, 0, 0));
        repeat (3) idle();
        idle();
        hand("int_vs_jump_redir", v(32'h90, 1, 1, 1, 0, 1, 0, 1));

        // Interrupt arriving during a jump flush is taken once the flush ends.
        step(1, 32'h500, 0, 0, 0, 0, '0);
        step(0, '0, 0, 0, 0, 1, 32'hA0);
        idle();
        hand("int_after_flush", v('0, 1, 0, 1, 0, 0, 0, 0));
        repeat (3) idle();
        idle();
        hand("int_after_flush_redir", v(32'hA0, 1, 1, 1, 0, 1, 0, 1));
        idle();

        // Reset in the middle of a drain aborts with no redirect.
        step(0, '0, 0, 0, 0, 1, 32'hC0);
        idle();
        idle();
        hand("pre_reset_drain", v('0, 1, 0, 1, 0, 1, 0, 1));
        rst = 1'b0;
        #1 check("reset_mid_drain", dut_vec, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        hand("after_reset", '0);
        repeat (4) begin
            idle();
            hand("no_redirect", '0);
        end

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
